sseg_scan_capture: RTL and testbench

Receive-side companion to the seven-segment time-multiplexing driver. The block watches the multiplexed `an`/`sseg` bus produced by the driver and reconstructs the four digit patterns it is scanning out. It decodes each pattern back to a hex nibble plus decimal point and reports complete scan frames and protocol errors. It is used as an on-chip loopback checker and as a self-checking monitor in display-path benches.

---
 rtl/sseg_scan_capture.sv | 136 +++++++++++++
 tb/tb_sseg_scan_capture.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: recovers the four digit patterns from a multiplexed an/sseg display bus
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   an[3:0]    anode enables, active-low, one-hot-low while a digit is driven
//   sseg[7:0]  segments, active-low, bit 7 = dp, bits 6..0 = g..a
//   digit      raw captured pattern per digit (8 bits each, active-low)
//   hex        decoded nibble per digit (4 bits each)
//   dp         decimal point per digit, active-high
//   hex_valid  captured g..a pattern is a hex glyph
//   frame_done one-cycle pulse once all four digits have been captured
//   scan_err   sticky, more than one anode low was seen
//   stale      digit not refreshed within STALE_MAX cycles
// Build option: define SSEG_CAP_STALE_EN to include the per-digit stale watchdog.
module sseg_scan_capture #(
  parameter int SETTLE    = 4,
  parameter int STALE_MAX = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [31:0] digit,
  output logic [15:0] hex,
  output logic [3:0]  dp,
  output logic [3:0]  hex_valid,
  output logic        frame_done,
  output logic        scan_err,
  output logic [3:0]  stale
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
  state_t st, st_n;
  logic [3:0] an_r, code, code_n, mask, mask_n;
  logic [7:0] sseg_r, pat, pat_n;
  logic [CW-1:0] cnt, cnt_n;
  logic onehot, multi, cap;
  logic [1:0] idx;
  function automatic logic [4:0] glyph(input logic [6:0] g);
    case (g)
      7'b1000000: glyph = 5'h10;
      7'b1111001: glyph = 5'h11;
      7'b0100100: glyph = 5'h12;
      7'b0110000: glyph = 5'h13;
      7'b0011001: glyph = 5'h14;
      7'b0010010: glyph = 5'h15;
      7'b0000010: glyph = 5'h16;
      7'b1111000: glyph = 5'h17;
      7'b0000000: glyph = 5'h18;
      7'b0010000: glyph = 5'h19;
      7'b0001000: glyph = 5'h1A;
      7'b0000011: glyph = 5'h1B;
      7'b1000110: glyph = 5'h1C;
      7'b0100001: glyph = 5'h1D;
      7'b0000110: glyph = 5'h1E;
      7'b0001110: glyph = 5'h1F;
      default:    glyph = 5'h00;
    endcase
  endfunction
  assign onehot = an_r inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  // anything that is neither one-hot-low nor all-high has at least two lows
  assign multi  = !onehot && an_r != 4'b1111;
  assign idx    = {~an_r[3] | ~an_r[2], ~an_r[3] | ~an_r[1]};
  assign mask_n = mask | (4'b0001 << idx);
  always_comb begin
    st_n   = st;
    code_n = code;
    pat_n  = pat;
    cnt_n  = cnt;
    cap    = 1'b0;
    if (!onehot)
      st_n = S_IDLE;
    // segment changes only restart the count while settling; HOLD ignores them
    else if (st == S_IDLE || an_r != code || (st == S_SETTLE && sseg_r != pat)) begin
      st_n   = S_SETTLE;
      code_n = an_r;
      pat_n  = sseg_r;
      cnt_n  = '0;
    end else if (st == S_SETTLE) begin
      cap   = cnt == CW'(SETTLE - 1);
      st_n  = cap ? S_HOLD : S_SETTLE;
      cnt_n = cap ? cnt : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_r       <= 4'b1111;
      sseg_r     <= 8'hFF;
      st         <= S_IDLE;
      code       <= 4'b1111;
      pat        <= 8'hFF;
      cnt        <= '0;
      mask       <= '0;
      digit      <= '1;
      hex        <= '0;
      dp         <= '0;
      hex_valid  <= '0;
      frame_done <= 1'b0;
      scan_err   <= 1'b0;
    end else begin
      an_r       <= an;
      sseg_r     <= sseg;
      st         <= st_n;
      code       <= code_n;
      pat        <= pat_n;
      cnt        <= cnt_n;
      frame_done <= 1'b0;
      if (multi)
        scan_err <= 1'b1;
      if (cap) begin
        digit[8*idx +: 8]                  <= sseg_r;
        dp[idx]                            <= ~sseg_r[7];
        {hex_valid[idx], hex[4*idx +: 4]}  <= glyph(sseg_r[6:0]);
        mask                               <= mask_n == 4'hF ? 4'h0 : mask_n;
        frame_done                         <= mask_n == 4'hF;
      end
    end
  end
`ifdef SSEG_CAP_STALE_EN
  localparam int SW = $clog2(STALE_MAX + 1);
  for (genvar i = 0; i < 4; i++) begin : g_age
    logic [SW-1:0] age;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        age <= '0;
      else if (cap && idx == 2'(i))
        age <= '0;
      else if (age != SW'(STALE_MAX))
        age <= age + 1'b1;
    end
    assign stale[i] = age == SW'(STALE_MAX);
  end
`else
  // watchdog not built; a non-positive STALE_MAX would mean "always stale"
  assign stale = {4{STALE_MAX < 1}};
`endif
endmodule

// File: tb/tb_sseg_scan_capture.sv
// tb_sseg_scan_capture: directed vector bench for sseg_scan_capture
module tb_sseg_scan_capture;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] an = 4'b1111;
  logic [7:0] sseg = 8'hFF;
  logic [31:0] digit;
  logic [15:0] hex;
  logic [3:0] dp, hex_valid, stale;
  logic frame_done, scan_err;
  int checks = 0;
  int fails = 0;
  int frames = 0;
  sseg_scan_capture #(.SETTLE(4), .STALE_MAX(100)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .sseg(sseg), .digit(digit), .hex(hex),
    .dp(dp), .hex_valid(hex_valid), .frame_done(frame_done), .scan_err(scan_err), .stale(stale)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) frames++;
  typedef struct {
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [15:0] exp_hex;
    logic [3:0]  exp_dp;
    logic [3:0]  exp_valid;
    int          exp_frames;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask
  task automatic put(input logic [3:0] a, input logic [7:0] s);
    step(a, s, 10);
    step(4'b1111, 8'hFF, 2);
  endtask
  function automatic int slot(input logic [3:0] a);
    int k = 0;
    for (int j = 0; j < 4; j++) if (!a[j]) k = j;
    return k;
  endfunction
  initial begin
    // sseg byte = {~dp, g..a}
    tbl[0] = '{4'b1110, 8'hB0, 16'h0003, 4'b0000, 4'b0001, 0};
    tbl[1] = '{4'b1101, 8'hC0, 16'h0003, 4'b0000, 4'b0011, 0};
    tbl[2] = '{4'b1011, 8'h0E, 16'h0F03, 4'b0100, 4'b0111, 0};
    tbl[3] = '{4'b0111, 8'h80, 16'h8F03, 4'b0100, 4'b1111, 1};
    tbl[4] = '{4'b1101, 8'hFF, 16'h8F03, 4'b0100, 4'b1101, 1};
    tbl[5] = '{4'b1101, 8'h88, 16'h8FA3, 4'b0100, 4'b1111, 1};
    tbl[6] = '{4'b1110, 8'h83, 16'h8FAB, 4'b0100, 4'b1111, 1};
    tbl[7] = '{4'b1011, 8'hC6, 16'h8CAB, 4'b0000, 4'b1111, 1};
    tbl[8] = '{4'b0111, 8'h21, 16'hDCAB, 4'b1000, 4'b1111, 2};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_digit", digit, 32'hFFFFFFFF);
    chk("reset_hex", 32'(hex), 32'h0);
    chk("reset_dp_valid", 32'({dp, hex_valid}), 32'h0);
    chk("reset_flags", 32'({frame_done, scan_err, stale}), 32'h0);
    step(4'b1110, 8'hB0, 3);
    step(4'b1111, 8'hFF, 10);
    chk("short_hold_digit", digit, 32'hFFFFFFFF);
    chk("short_hold_frames", 32'(frames), 32'd0);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].an, tbl[i].sseg, 20);
      chk($sformatf("vec%0d_digit", i), 32'(digit[8*slot(tbl[i].an) +: 8]), 32'(tbl[i].sseg));
      chk($sformatf("vec%0d_hex", i), 32'(hex), 32'(tbl[i].exp_hex));
      chk($sformatf("vec%0d_dp", i), 32'(dp), 32'(tbl[i].exp_dp));
      chk($sformatf("vec%0d_valid", i), 32'(hex_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_frames", i), 32'(frames), 32'(tbl[i].exp_frames));
      step(4'b1111, 8'hFF, 2);
    end
    put(4'b1110, 8'h83);
    put(4'b1101, 8'h88);
    put(4'b1011, 8'hC6);
    step(4'b0111, 8'hF8, 5);
    chk("lat5_digit3", 32'(digit[31:24]), 32'h21);
    chk("lat5_frame", 32'(frame_done), 32'h0);
    @(negedge clk);
    chk("lat6_digit3", 32'(digit[31:24]), 32'hF8);
    chk("lat6_hex3", 32'(hex[15:12]), 32'h7);
    chk("lat6_frame", 32'(frame_done), 32'h1);
    @(negedge clk);
    chk("lat7_frame", 32'(frame_done), 32'h0);
    step(4'b1111, 8'hFF, 2);
    chk("frames_3", 32'(frames), 32'd3);
    for (int i = 0; i < 15; i++) begin
      step(4'b1011, 8'h86, 2);
      step(4'b1011, 8'hF9, 2);
    end
    chk("toggle_no_cap", 32'(digit[23:16]), 32'hC6);
    step(4'b1011, 8'hF9, 8);
    chk("toggle_then_cap", 32'(digit[23:16]), 32'hF9);
    chk("toggle_then_hex", 32'(hex[11:8]), 32'h1);
    step(4'b1111, 8'hFF, 2);
    chk("err_before", 32'(scan_err), 32'h0);
    step(4'b1100, 8'h80, 1);
    chk("err_lat1", 32'(scan_err), 32'h0);
    step(4'b1100, 8'h80, 1);
    chk("err_lat2", 32'(scan_err), 32'h1);
    step(4'b1100, 8'h80, 8);
    chk("err_no_cap", digit, 32'hF8F98883);
    step(4'b1111, 8'hFF, 2);
    put(4'b1110, 8'hB0);
    put(4'b1101, 8'hC0);
    put(4'b1011, 8'h0E);
    put(4'b0111, 8'h80);
    chk("err_frame_hex", 32'(hex), 32'h8F03);
    chk("err_sticky", 32'(scan_err), 32'h1);
    chk("frames_4", 32'(frames), 32'd4);
    put(4'b1110, 8'h83);
    #3 reset_n = 1'b0;
    #1;
    chk("async_digit", digit, 32'hFFFFFFFF);
    chk("async_rest", 32'({hex, dp, hex_valid, scan_err}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    put(4'b1101, 8'hC0);
    put(4'b1011, 8'h0E);
    put(4'b0111, 8'h80);
    chk("no_partial_frame", 32'(frames), 32'd4);
    put(4'b1110, 8'hB0);
    chk("frame_after_reset", 32'(frames), 32'd5);
`ifdef SSEG_CAP_STALE_EN
    for (int i = 0; i < 7; i++) begin
      put(4'b1110, 8'hB0);
      put(4'b1101, 8'hC0);
      put(4'b1011, 8'h0E);
    end
    chk("stale_d3", 32'(stale), 32'b1000);
    step(4'b0111, 8'h80, 5);
    chk("stale_d3_before", 32'(stale), 32'b1000);
    @(negedge clk);
    chk("stale_d3_cleared", 32'(stale), 32'b0000);
`else
    chk("stale_off", 32'(stale), 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
